// File: rtl/jam_pkg.sv
// Shared widths, constants, state encoding and helpers for the cost-port arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jam_pkg;

    localparam int IDX_W  = 3;
    localparam int COST_W = 7;
    localparam int MIN_W  = 10;
    localparam int CNT_W  = 4;

    localparam logic [MIN_W-1:0] MIN_INIT = 10'd1023;

    // Encoding doubles as the one-hot grant vector: bit k set means engine k owns the port.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_t;

    // One engine's partial search result.
    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [CNT_W-1:0] cnt;
    } result_t;

    // Match counts add up to the counter width and stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/jam_result_merge.sv
// Latches each engine's partial (min, count) on done and merges them once both are in.
// Latency: Valid pulses in the cycle after the later done (a done counts in its own cycle).
// Backpressure: none; a repeated done before the merge overwrites that engine's values.
module jam_result_merge
    import jam_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            done,
    input  logic [1:0][MIN_W-1:0] min_in,
    input  logic [1:0][CNT_W-1:0] cnt_in,
    output logic [MIN_W-1:0]      MinCost,
    output logic [CNT_W-1:0]      MatchCount,
    output logic                  Valid
);

    logic [1:0]    flag;
    result_t [1:0] lat;
    logic [1:0]    eff_flag;
    result_t [1:0] eff;
    logic          merge;
    result_t       merged;

    // Fold this cycle's done into the latched state so the merge fires without an extra cycle.
    always_comb begin
        eff_flag = flag | done;
        for (int k = 0; k < 2; k++) begin
            eff[k] = done[k] ? result_t'{min: min_in[k], cnt: cnt_in[k]} : lat[k];
        end
        merge = &eff_flag;
        if (eff[0].min < eff[1].min) begin
            merged = eff[0];
        end else if (eff[1].min < eff[0].min) begin
            merged = eff[1];
        end else begin
            merged = result_t'{min: eff[0].min, cnt: sat_add(eff[0].cnt, eff[1].cnt)};
        end
    end

    // Hold partials until both engines report, then publish and start over.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flag       <= 2'b00;
            lat        <= '0;
            MinCost    <= MIN_INIT;
            MatchCount <= '0;
            Valid      <= 1'b0;
        end else begin
            Valid <= merge;
            for (int k = 0; k < 2; k++) begin
                if (done[k]) begin
                    lat[k] <= eff[k];
                end
            end
            if (merge) begin
                flag       <= 2'b00;
                MinCost    <= merged.min;
                MatchCount <= merged.cnt;
            end else begin
                flag <= eff_flag;
            end
        end
    end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Round-robin, burst-locked sharing of the cost-table port between two search engines.
// Latency: grant one cycle after request; read data one cycle after its beat; no bubble on hand-over.
// Backpressure: a granted engine stalls by dropping req; a waiting peer takes over after BURST_LEN beats.
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int BURST_LEN = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             req,
    input  logic [1:0][IDX_W-1:0]  w_in,
    input  logic [1:0][IDX_W-1:0]  j_in,
    output logic [1:0]             gnt,
    output logic [COST_W-1:0]      rdata,
    output logic [1:0]             rvalid,
    output logic [IDX_W-1:0]       W,
    output logic [IDX_W-1:0]       J,
    input  logic [COST_W-1:0]      Cost,
    input  logic [1:0]             done,
    input  logic [1:0][MIN_W-1:0]  min_in,
    input  logic [1:0][CNT_W-1:0]  cnt_in,
    output logic [MIN_W-1:0]       MinCost,
    output logic [CNT_W-1:0]       MatchCount,
    output logic                   Valid
);

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

    arb_state_t     state, state_nxt;
    logic           last, last_nxt;
    logic [3:0]     beat_cnt, beat_cnt_nxt;
    logic           cur, oth, beat;
    logic [IDX_W-1:0] w_hold, j_hold;

    function automatic arb_state_t grant_of(input logic k);
        return k ? G1 : G0;
    endfunction

    // The state encoding is the grant vector, so gnt comes straight off the state flops.
    assign gnt = state;

    // A beat happens only when the current owner is actually asking this cycle.
    always_comb begin
        cur  = (state == G1);
        oth  = ~cur;
        beat = (state != IDLE) && req[cur];
        W    = beat ? w_in[cur] : w_hold;
        J    = beat ? j_in[cur] : j_hold;
    end

    // Grant selection: round-robin from idle, hand-over on drop or on burst end with a waiting peer.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        beat_cnt_nxt = beat_cnt;
        if (state == IDLE) begin
            if (|req) begin
                state_nxt    = grant_of((&req) ? ~last : req[1]);
                last_nxt     = (&req) ? ~last : req[1];
                beat_cnt_nxt = '0;
            end
        end else if (!req[cur]) begin
            beat_cnt_nxt = '0;
            if (req[oth]) begin
                state_nxt = grant_of(oth);
                last_nxt  = oth;
            end else begin
                state_nxt = IDLE;
            end
        end else if (beat_cnt == BURST_LAST) begin
            // Burst complete: the counter restarts whether or not ownership changes.
            beat_cnt_nxt = '0;
            if (req[oth]) begin
                state_nxt = grant_of(oth);
                last_nxt  = oth;
            end
        end else begin
            beat_cnt_nxt = beat_cnt + 4'd1;
        end
    end

    // Arbiter state, round-robin pointer and burst counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            last     <= 1'b1;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Capture the table response and remember the last index pair driven to the table.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata  <= '0;
            rvalid <= 2'b00;
            w_hold <= '0;
            j_hold <= '0;
        end else begin
            rvalid <= beat ? (cur ? 2'b10 : 2'b01) : 2'b00;
            if (beat) begin
                rdata  <= Cost;
                w_hold <= W;
                j_hold <= J;
            end
        end
    end

    jam_result_merge u_merge (
        .CLK        (CLK),
        .RST        (RST),
        .done       (done),
        .min_in     (min_in),
        .cnt_in     (cnt_in),
        .MinCost    (MinCost),
        .MatchCount (MatchCount),
        .Valid      (Valid)
    );

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Bench for jam_cost_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model of port ownership and result merging.
// The cost table is emulated as Cost = W*10 + J.
module tb_jam_cost_arbiter;

    logic            CLK;
    logic            RST;
    logic [1:0]      req;
    logic [1:0][2:0] w_in;
    logic [1:0][2:0] j_in;
    logic [1:0]      gnt;
    logic [6:0]      rdata;
    logic [1:0]      rvalid;
    logic [2:0]      W;
    logic [2:0]      J;
    logic [6:0]      Cost;
    logic [1:0]      done;
    logic [1:0][9:0] min_in;
    logic [1:0][3:0] cnt_in;
    logic [9:0]      MinCost;
    logic [3:0]      MatchCount;
    logic            Valid;

    jam_cost_arbiter #(.BURST_LEN(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .w_in       (w_in),
        .j_in       (j_in),
        .gnt        (gnt),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .done       (done),
        .min_in     (min_in),
        .cnt_in     (cnt_in),
        .MinCost    (MinCost),
        .MatchCount (MatchCount),
        .Valid      (Valid)
    );

    assign Cost = 7'(int'(W) * 10 + int'(J));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int passes = 0;

    // Behavioural model: who owns the port, how many beats it has used, what the table last returned.
    int   m_owner;
    int   m_beats;
    int   m_last;
    int   m_hw, m_hj, m_rd, m_rv;
    int   pend [2];
    int   pmin [2];
    int   pcnt [2];
    int   m_min, m_cnt, m_valid;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_last = 1;
        m_hw = 0; m_hj = 0; m_rd = 0; m_rv = 0;
        for (int k = 0; k < 2; k++) begin pend[k] = 0; pmin[k] = 0; pcnt[k] = 0; end
        m_min = 1023; m_cnt = 0; m_valid = 0;
    endtask

    function automatic bit owner_beats();
        return (m_owner >= 0) && req[m_owner];
    endfunction

    task automatic model_compare();
        int ew, ej;
        ew = owner_beats() ? int'(w_in[m_owner]) : m_hw;
        ej = owner_beats() ? int'(j_in[m_owner]) : m_hj;
        check("gnt",        int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
        check("W",          int'(W), ew);
        check("J",          int'(J), ej);
        check("rdata",      int'(rdata), m_rd);
        check("rvalid",     int'(rvalid), m_rv);
        check("MinCost",    int'(MinCost), m_min);
        check("MatchCount", int'(MatchCount), m_cnt);
        check("Valid",      int'(Valid), m_valid);
    endtask

    // Advance the model across one rising edge using the inputs presented this cycle.
    task automatic model_step();
        int o;
        if (owner_beats()) begin
            m_hw = int'(w_in[m_owner]);
            m_hj = int'(j_in[m_owner]);
            m_rd = m_hw * 10 + m_hj;
            m_rv = 1 << m_owner;
        end else begin
            m_rv = 0;
        end
        if (m_owner < 0) begin
            if (req != 2'b00) begin
                m_owner = (req == 2'b11) ? 1 - m_last : (req[0] ? 0 : 1);
                m_last  = m_owner;
                m_beats = 0;
            end
        end else if (!req[m_owner]) begin
            o = 1 - m_owner;
            m_owner = req[o] ? o : -1;
            if (m_owner >= 0) m_last = m_owner;
            m_beats = 0;
        end else begin
            m_beats++;
            if (m_beats == 8) begin
                m_beats = 0;
                if (req[1 - m_owner]) begin
                    m_owner = 1 - m_owner;
                    m_last  = m_owner;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (done[k]) begin pend[k] = 1; pmin[k] = int'(min_in[k]); pcnt[k] = int'(cnt_in[k]); end
        end
        if (pend[0] == 1 && pend[1] == 1) begin
            if (pmin[0] < pmin[1])      begin m_min = pmin[0]; m_cnt = pcnt[0]; end
            else if (pmin[1] < pmin[0]) begin m_min = pmin[1]; m_cnt = pcnt[1]; end
            else begin m_min = pmin[0]; m_cnt = (pcnt[0] + pcnt[1] > 15) ? 15 : pcnt[0] + pcnt[1]; end
            m_valid = 1;
            pend[0] = 0; pend[1] = 0;
        end else begin
            m_valid = 0;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        @(negedge CLK);
        model_compare();
        if (!RST) model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; req = 2'b00; done = 2'b00;
        model_reset();
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    task automatic drive_done(input logic [1:0] d, input int m0, input int c0, input int m1, input int c1);
        done = d;
        min_in[0] = 10'(m0); cnt_in[0] = 4'(c0);
        min_in[1] = 10'(m1); cnt_in[1] = 4'(c1);
        cycle();
        done = 2'b00;
    endtask

    int rst_hold;

    initial begin
        RST = 1'b1; req = 2'b00; done = 2'b00;
        w_in = '0; j_in = '0; min_in = '0; cnt_in = '0;
        model_reset();
        cycle();
        check("reset_gnt", int'(gnt), 0);
        check("reset_rvalid", int'(rvalid), 0);
        check("reset_MinCost", int'(MinCost), 1023);
        check("reset_MatchCount", int'(MatchCount), 0);
        check("reset_W", int'(W), 0);
        cycle();
        RST = 1'b0;

        // Engine 0 alone, eight beats walking the table diagonal.
        req = 2'b01;
        cycle();
        check("e0_req_to_gnt", int'(gnt), 1);
        for (int i = 0; i < 8; i++) begin
            w_in[0] = 3'(i); j_in[0] = 3'(7 - i);
            cycle();
            check("e0_rdata", int'(rdata), 9 * i + 7);
            check("e0_rvalid", int'(rvalid), 1);
        end
        check("e0_burst_keeps_gnt", int'(gnt), 1);
        req = 2'b00;
        cycle();
        check("e0_drop_no_rvalid", int'(rvalid), 0);
        check("e0_drop_idle", int'(gnt), 0);

        // Both engines requesting from reset: alternating bursts of eight with no gap.
        do_reset();
        req = 2'b11;
        cycle();
        check("both_first_gnt", int'(gnt), 1);
        for (int c = 1; c <= 32; c++) begin
            w_in[0] = 3'($urandom_range(7)); j_in[0] = 3'($urandom_range(7));
            w_in[1] = 3'($urandom_range(7)); j_in[1] = 3'($urandom_range(7));
            cycle();
            check("both_gnt", int'(gnt), ((c / 8) % 2 == 0) ? 1 : 2);
            check("both_rvalid", int'(rvalid), (((c - 1) / 8) % 2 == 0) ? 1 : 2);
        end

        // Engine 0 drops after three beats; engine 1 gets a fresh full burst.
        do_reset();
        req = 2'b11;
        cycle();
        repeat (3) cycle();
        req = 2'b10;
        cycle();
        check("drop_no_beat", int'(rvalid), 0);
        check("drop_gnt_moves", int'(gnt), 2);
        req = 2'b11;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            check("drop_e1_burst", int'(gnt), (c < 8) ? 2 : 1);
        end
        req = 2'b00;
        cycle();
        cycle();

        // Result merging.
        drive_done(2'b01, 300, 2, 0, 0);
        check("merge_wait", int'(Valid), 0);
        cycle();
        cycle();
        drive_done(2'b10, 0, 0, 300, 5);
        check("merge_eq_valid", int'(Valid), 1);
        check("merge_eq_min", int'(MinCost), 300);
        check("merge_eq_cnt", int'(MatchCount), 7);
        cycle();
        check("merge_valid_pulse", int'(Valid), 0);
        check("merge_hold", int'(MinCost), 300);
        drive_done(2'b11, 250, 3, 400, 1);
        check("merge_sim_min", int'(MinCost), 250);
        check("merge_sim_cnt", int'(MatchCount), 3);
        drive_done(2'b11, 500, 12, 500, 9);
        check("merge_sat_cnt", int'(MatchCount), 15);
        drive_done(2'b11, 600, 4, 100, 6);
        check("merge_e1_min", int'(MinCost), 100);
        check("merge_e1_cnt", int'(MatchCount), 6);
        drive_done(2'b01, 50, 1, 0, 0);
        drive_done(2'b01, 80, 2, 0, 0);
        drive_done(2'b10, 0, 0, 90, 3);
        check("merge_overwrite_min", int'(MinCost), 80);
        check("merge_overwrite_cnt", int'(MatchCount), 2);

        // Reset in the middle of a burst with a read result in flight.
        do_reset();
        req = 2'b01;
        cycle();
        repeat (3) cycle();
        check("mid_rvalid_pending", int'(rvalid), 1);
        RST = 1'b1;
        #1;
        check("rst_rvalid_drop", int'(rvalid), 0);
        check("rst_gnt", int'(gnt), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_MinCost", int'(MinCost), 1023);
        check("rst_Valid", int'(Valid), 0);
        model_reset();
        cycle();
        RST = 1'b0;
        req = 2'b11;
        cycle();
        check("rst_restart_e0", int'(gnt), 1);

        // Randomized traffic against the model.
        rst_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) RST = 1'b0;
            end else if ($urandom_range(499) == 0) begin
                RST = 1'b1;
                rst_hold = 2;
                model_reset();
            end
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(5) == 0) req[k] = ~req[k];
                w_in[k]   = 3'($urandom_range(7));
                j_in[k]   = 3'($urandom_range(7));
                done[k]   = ($urandom_range(19) == 0);
                min_in[k] = 10'($urandom_range(1023));
                cnt_in[k] = 4'($urandom_range(15));
            end
            if ($urandom_range(3) == 0) min_in[1] = min_in[0];
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/jam_cost_arbiter.md
# jam_cost_arbiter

Shares the single external cost-table port (W/J in, Cost back) between two job-assignment search engines. Each engine searches half of the permutation space. Grants are round-robin, burst-locked per permutation (8 reads). When both engines finish, the block merges their partial results into the final MinCost / MatchCount and pulses Valid. It sits between the engines and the top-level cost port.

## Interface
Parameters:
- BURST_LEN, 8, beats a granted engine may hold the port before yielding to a waiting peer (range 1..15)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- req  in  2  per-engine port request; held high while reads are wanted
- w_in  in  2x3  per-engine worker index
- j_in  in  2x3  per-engine job index
- gnt  out  2  one-hot grant; registered
- rdata  out  7  returned cost, shared by both engines
- rvalid  out  2  one-hot; rdata belongs to engine k
- W  out  3  worker index to the cost table
- J  out  3  job index to the cost table
- Cost  in  7  cost table data; combinational response to W/J in the same cycle
- done  in  2  one-cycle pulse per engine: its search is finished
- min_in  in  2x10  engine partial minimum, valid with done
- cnt_in  in  2x4  engine partial match count, valid with done
- MinCost  out  10  merged minimum
- MatchCount  out  4  merged match count
- Valid  out  1  one-cycle pulse: merged result is ready

## Operation
- Arbiter FSM has three states:
  - IDLE: gnt=00.
  - G0: gnt=01.
  - G1: gnt=10.
- Round-robin pointer `last` names the most recently granted engine. Reset value: 1, so engine 0 wins first.
- IDLE: if any req is high, go to G(k), where k is the requester after `last`. If only one requests, grant it.
- G(k): a beat is accepted on each cycle with req[k]=1.
  - While a beat is accepted, W=w_in[k] and J=j_in[k] (combinational mux).
  - Cost is registered into rdata, and rvalid[k]=1 on the following cycle.
- beat_cnt counts accepted beats in the current grant and clears on every grant change.
- Leaving G(k):
  - If req[k]=0: go to G(other) if req[other]=1, else IDLE.
  - If beat_cnt reaches BURST_LEN and req[other]=1: go to G(other).
  - If beat_cnt reaches BURST_LEN and the peer is idle: stay in G(k) with beat_cnt cleared.
- Without a granted beat, W/J hold their last values, and no rvalid is produced one cycle later.
- Merge logic:
  - done[k] latches min_in[k] and cnt_in[k] and sets flag[k].
  - Simultaneous done on both engines latches both.
  - A second done[k] before the merge overwrites that engine's latched values.
- When both flags are set, the next edge writes the merged result, pulses Valid for one cycle, and clears both flags:
  - If min0 < min1: MinCost=min0, MatchCount=cnt0.
  - If min1 < min0: MinCost=min1, MatchCount=cnt1.
  - If equal: MinCost=min0, MatchCount=cnt0+cnt1, saturating at 15.
- MinCost and MatchCount hold between merges. Arbitration and merging are independent.

## Timing
- Reset values: gnt=00, rvalid=00, rdata=0, W=0, J=0, MinCost=1023, MatchCount=0, Valid=0, flags=00, beat_cnt=0, state=IDLE.
- Request-to-grant latency: req rises at edge n, gnt is seen from n+1.
- Read latency: beat in cycle c, rdata/rvalid valid in cycle c+1. Back-to-back beats give one result per cycle.
- Grant switch costs zero bubble cycles: last beat of engine k at cycle c, first beat of the other engine at c+1.
- done-to-Valid latency: Valid is high in the cycle after the later done.
- Reset mid-burst: everything returns to reset values, including the in-flight rvalid, which is dropped. Engines must re-request.
- req[k] dropped during G(k): no beat that cycle, and the grant moves at the next edge.

## Structure
- Shared package jam_pkg holds:
  - widths IDX_W=3, COST_W=7, MIN_W=10, CNT_W=4
  - constant MIN_INIT=1023
  - arbiter state enum {IDLE, G0, G1}
- Sub-module jam_result_merge holds the flags, latches, compare/sum/saturate logic and the Valid pulse. Arbiter and port mux stay in the top.

## Test plan
- Engine 0 alone, 8 beats (w=0..7, j=7..0), Cost=w*10+j: gnt=01 one cycle after req; rdata 7,16,…,70 with rvalid=01, each one cycle after its beat.
- Both req held high from reset: grants 8 beats to engine 0, then 8 to engine 1, alternating, with no idle cycle between bursts.
- Engine 0 drops req after 3 beats while engine 1 waits: gnt=10 in the cycle after the drop; beat_cnt restarts.
- done0 (min=300, cnt=2), then done1 (min=300, cnt=5) three cycles later: MinCost=300, MatchCount=7, Valid one cycle after done1. Simultaneous done with min 250/400, cnt 3/1: MinCost=250, MatchCount=3.
- Equal minimum with cnt 12+9: MatchCount=15 (saturated).
- RST asserted mid-burst with rvalid pending: rvalid=00 immediately, all outputs at reset values, arbitration restarts with engine 0.
